instr_pipe_chain: RTL and testbench

//  Parametrised multi-stage instruction/PC pipeline; successor to the single-stage instruction pipe register.

---
 rtl/instr_pipe_chain.sv | 132 +++++++++++++
 tb/tb_instr_pipe_chain.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_pipe_chain.sv
// -----------------------------------------------------------------------------
// instr_pipe_chain
//   Multi-stage instruction/PC pipeline between fetch and decode/execute.
//   Carries {instr, pc, valid} through STAGES register stages. A global stall
//   holds every stage, and a flush turns every stage into a bubble. The block
//   also reports how many stages hold a valid instruction and counts retired
//   instructions.
//
// Parameters
//   STAGES     number of register stages (>=1); latency in edges
//   INSTR_W    instruction width
//   PC_W       program counter width
//   NOP_INSTR  instruction value held by a bubble stage
//   CNT_W      width of retire_cnt
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   instr_in     in   instruction entering stage 1
//   counter_in   in   PC paired with instr_in
//   valid_in     in   instr_in/counter_in carry a real instruction
//   stall        in   1 = every stage holds and the input is dropped
//   flush        in   1 = every stage becomes a bubble (overrides stall)
//   instr_out    out  last-stage instruction
//   counter_out  out  last-stage PC
//   valid_out    out  last-stage valid
//   occupancy    out  number of stages with valid=1
//   retire_cnt   out  instructions that left the last stage (wraps)
//
// Optional feature (macro PIPE_STAGE_TAP_EN)
//   stage_instr  out  all stage instructions, stage 1 in the LSBs
//   stage_valid  out  per-stage valid, bit 0 = stage 1
//   Used by forwarding/hazard logic. When the macro is undefined these ports
//   are absent and cycle behaviour is otherwise identical.
// -----------------------------------------------------------------------------
module instr_pipe_chain #(
    parameter int                 STAGES    = 3,
    parameter int                 INSTR_W   = 11,
    parameter int                 PC_W      = 6,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter int                 CNT_W     = 16,
    localparam int                OCC_W     = $clog2(STAGES + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [INSTR_W-1:0]          instr_in,
    input  logic [PC_W-1:0]             counter_in,
    input  logic                        valid_in,
    input  logic                        stall,
    input  logic                        flush,
    output logic [INSTR_W-1:0]          instr_out,
    output logic [PC_W-1:0]             counter_out,
    output logic                        valid_out,
    output logic [OCC_W-1:0]            occupancy,
    output logic [CNT_W-1:0]            retire_cnt
`ifdef PIPE_STAGE_TAP_EN
    ,
    output logic [STAGES*INSTR_W-1:0]   stage_instr,
    output logic [STAGES-1:0]           stage_valid
`endif
);

    // Index 0 is stage 1 (entry); index STAGES-1 drives the outputs.
    logic [INSTR_W-1:0] instr_q [STAGES];
    logic [PC_W-1:0]    pc_q    [STAGES];
    logic [STAGES-1:0]  valid_q;

    // NOTE: all state below uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value; blocking assignments here
    // would ripple one input through the whole chain in a single edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the stage arrays are a handful of flops, not a RAM, so
            // they are reset explicitly; an in-flight instruction must never
            // survive reset.
            for (int i = 0; i < STAGES; i++) begin
                instr_q[i] <= NOP_INSTR;
                pc_q[i]    <= '0;
            end
            valid_q    <= '0;
            retire_cnt <= '0;
        end else if (flush) begin
            // Flush wins over stall; the last-stage instruction is discarded
            // and therefore not counted as retired.
            for (int i = 0; i < STAGES; i++) begin
                instr_q[i] <= NOP_INSTR;
                pc_q[i]    <= '0;
            end
            valid_q <= '0;
        end else if (!stall) begin
            // An invalid input enters as a clean bubble so no stale
            // instruction/PC bits travel down the pipe.
            instr_q[0] <= valid_in ? instr_in   : NOP_INSTR;
            pc_q[0]    <= valid_in ? counter_in : '0;
            valid_q[0] <= valid_in;
            for (int i = 1; i < STAGES; i++) begin
                instr_q[i] <= instr_q[i-1];
                pc_q[i]    <= pc_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
            // The last stage is leaving this edge.
            if (valid_q[STAGES-1]) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

    assign instr_out   = instr_q[STAGES-1];
    assign counter_out = pc_q[STAGES-1];
    assign valid_out   = valid_q[STAGES-1];

    // NOTE: the accumulator gets its default before the loop, so the block
    // stays purely combinational and no latch is inferred.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + OCC_W'(valid_q[i]);
        end
    end

`ifdef PIPE_STAGE_TAP_EN
    always_comb begin
        stage_instr = '0;
        for (int i = 0; i < STAGES; i++) begin
            stage_instr[i*INSTR_W +: INSTR_W] = instr_q[i];
        end
    end

    assign stage_valid = valid_q;
`endif

endmodule

// File: tb/tb_instr_pipe_chain.sv
// -----------------------------------------------------------------------------
// tb_instr_pipe_chain
//   Directed, table-driven bench for instr_pipe_chain. Three instances share
//   one stimulus: the main 3-stage pipe, a 3-stage pipe with a 4-bit retire
//   counter (wrap behaviour) and a 1-stage pipe (plain register latency).
//   Expected values are hand-computed in the vector table and hand sequences.
// -----------------------------------------------------------------------------
module tb_instr_pipe_chain;

    logic        clk;
    logic        rst_n;
    logic [10:0] instr_in;
    logic [5:0]  counter_in;
    logic        valid_in;
    logic        stall;
    logic        flush;

    // Main 3-stage instance.
    logic [10:0] instr_out;
    logic [5:0]  counter_out;
    logic        valid_out;
    logic [1:0]  occupancy;
    logic [15:0] retire_cnt;

    // 3-stage instance with a 4-bit retire counter.
    logic [10:0] instr_w;
    logic [5:0]  pc_w;
    logic        valid_w;
    logic [1:0]  occ_w;
    logic [3:0]  retire_w;

    // 1-stage instance.
    logic [10:0] instr1;
    logic [5:0]  pc1;
    logic        valid1;
    logic [0:0]  occ1;
    logic [15:0] retire1;

`ifdef PIPE_STAGE_TAP_EN
    logic [32:0] tap_instr3;
    logic [2:0]  tap_valid3;
    logic [32:0] tap_instr_w;
    logic [2:0]  tap_valid_w;
    logic [10:0] tap_instr1;
    logic [0:0]  tap_valid1;
`endif

    int checks   = 0;
    int failures = 0;

    instr_pipe_chain #(.STAGES(3), .INSTR_W(11), .PC_W(6), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .counter_in(counter_in),
        .valid_in(valid_in), .stall(stall), .flush(flush),
        .instr_out(instr_out), .counter_out(counter_out), .valid_out(valid_out),
        .occupancy(occupancy), .retire_cnt(retire_cnt)
`ifdef PIPE_STAGE_TAP_EN
        , .stage_instr(tap_instr3), .stage_valid(tap_valid3)
`endif
    );

    instr_pipe_chain #(.STAGES(3), .INSTR_W(11), .PC_W(6), .CNT_W(4)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .counter_in(counter_in),
        .valid_in(valid_in), .stall(stall), .flush(flush),
        .instr_out(instr_w), .counter_out(pc_w), .valid_out(valid_w),
        .occupancy(occ_w), .retire_cnt(retire_w)
`ifdef PIPE_STAGE_TAP_EN
        , .stage_instr(tap_instr_w), .stage_valid(tap_valid_w)
`endif
    );

    instr_pipe_chain #(.STAGES(1), .INSTR_W(11), .PC_W(6), .CNT_W(16)) dut_one (
        .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .counter_in(counter_in),
        .valid_in(valid_in), .stall(stall), .flush(flush),
        .instr_out(instr1), .counter_out(pc1), .valid_out(valid1),
        .occupancy(occ1), .retire_cnt(retire1)
`ifdef PIPE_STAGE_TAP_EN
        , .stage_instr(tap_instr1), .stage_valid(tap_valid1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net: the sequence is a few hundred cycles.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vi, input logic [10:0] ins, input logic [5:0] pc,
                         input logic st, input logic fl);
        valid_in   = vi;
        instr_in   = ins;
        counter_in = pc;
        stall      = st;
        flush      = fl;
    endtask

    task automatic check_one(input string tag, input logic [10:0] ei, input logic [5:0] ep,
                             input logic ev);
        check({tag, " one instr"}, 32'(instr1), 32'(ei));
        check({tag, " one pc"},    32'(pc1),    32'(ep));
        check({tag, " one valid"}, 32'(valid1), 32'(ev));
        check({tag, " one occ"},   32'(occ1),   32'(ev));
`ifdef PIPE_STAGE_TAP_EN
        check({tag, " one tap instr"}, 32'(tap_instr1), 32'(ei));
        check({tag, " one tap valid"}, 32'(tap_valid1), 32'(ev));
`endif
    endtask

    typedef struct {
        logic        vi;
        logic [10:0] instr;
        logic [5:0]  pc;
        logic        st;
        logic        fl;
        logic        ev;
        logic [10:0] ei;
        logic [5:0]  ep;
        logic [1:0]  eo;
        logic [15:0] er;
    } vec_t;

    vec_t vecs [23];

    initial begin
        // Inputs applied before an edge, expected main-pipe outputs after it.
        //           vi    instr    pc     stall flush  ev    ei       ep     occ   retire
        // Stream 7FF/000/6B5
        vecs[0]  = '{1'b1, 11'h7FF, 6'd1,  1'b0, 1'b0, 1'b0, 11'h000, 6'd0,  2'd1, 16'd0};
        vecs[1]  = '{1'b1, 11'h000, 6'd2,  1'b0, 1'b0, 1'b0, 11'h000, 6'd0,  2'd2, 16'd0};
        vecs[2]  = '{1'b1, 11'h6B5, 6'd3,  1'b0, 1'b0, 1'b1, 11'h7FF, 6'd1,  2'd3, 16'd0};
        // Stall four cycles with 0x155 offered: everything frozen
        vecs[3]  = '{1'b1, 11'h155, 6'd4,  1'b1, 1'b0, 1'b1, 11'h7FF, 6'd1,  2'd3, 16'd0};
        vecs[4]  = '{1'b1, 11'h155, 6'd4,  1'b1, 1'b0, 1'b1, 11'h7FF, 6'd1,  2'd3, 16'd0};
        vecs[5]  = '{1'b1, 11'h155, 6'd4,  1'b1, 1'b0, 1'b1, 11'h7FF, 6'd1,  2'd3, 16'd0};
        vecs[6]  = '{1'b1, 11'h155, 6'd4,  1'b1, 1'b0, 1'b1, 11'h7FF, 6'd1,  2'd3, 16'd0};
        // Release with invalid (garbage) input: order resumes, drains
        vecs[7]  = '{1'b0, 11'h155, 6'd4,  1'b0, 1'b0, 1'b1, 11'h000, 6'd2,  2'd2, 16'd1};
        vecs[8]  = '{1'b0, 11'h123, 6'd5,  1'b0, 1'b0, 1'b1, 11'h6B5, 6'd3,  2'd1, 16'd2};
        vecs[9]  = '{1'b0, 11'h000, 6'd0,  1'b0, 1'b0, 1'b0, 11'h000, 6'd0,  2'd0, 16'd3};
        // Alternating valid/bubble
        vecs[10] = '{1'b1, 11'h0AA, 6'd10, 1'b0, 1'b0, 1'b0, 11'h000, 6'd0,  2'd1, 16'd3};
        vecs[11] = '{1'b0, 11'h3C3, 6'd11, 1'b0, 1'b0, 1'b0, 11'h000, 6'd0,  2'd1, 16'd3};
        vecs[12] = '{1'b1, 11'h111, 6'd12, 1'b0, 1'b0, 1'b1, 11'h0AA, 6'd10, 2'd2, 16'd3};
        vecs[13] = '{1'b0, 11'h222, 6'd13, 1'b0, 1'b0, 1'b0, 11'h000, 6'd0,  2'd1, 16'd4};
        vecs[14] = '{1'b1, 11'h333, 6'd14, 1'b0, 1'b0, 1'b1, 11'h111, 6'd12, 2'd2, 16'd4};
        vecs[15] = '{1'b0, 11'h000, 6'd0,  1'b0, 1'b0, 1'b0, 11'h000, 6'd0,  2'd1, 16'd5};
        // Fill, then flush+stall together
        vecs[16] = '{1'b1, 11'h401, 6'd16, 1'b0, 1'b0, 1'b1, 11'h333, 6'd14, 2'd2, 16'd5};
        vecs[17] = '{1'b1, 11'h402, 6'd17, 1'b0, 1'b0, 1'b0, 11'h000, 6'd0,  2'd2, 16'd6};
        vecs[18] = '{1'b1, 11'h403, 6'd18, 1'b0, 1'b0, 1'b1, 11'h401, 6'd16, 2'd3, 16'd6};
        vecs[19] = '{1'b1, 11'h7AA, 6'd19, 1'b1, 1'b1, 1'b0, 11'h000, 6'd0,  2'd0, 16'd6};
        vecs[20] = '{1'b0, 11'h000, 6'd0,  1'b0, 1'b0, 1'b0, 11'h000, 6'd0,  2'd0, 16'd6};
        // Flush alone discards the input of that cycle
        vecs[21] = '{1'b1, 11'h0F0, 6'd21, 1'b0, 1'b0, 1'b0, 11'h000, 6'd0,  2'd1, 16'd6};
        vecs[22] = '{1'b1, 11'h0F1, 6'd22, 1'b0, 1'b1, 1'b0, 11'h000, 6'd0,  2'd0, 16'd6};

        rst_n = 1'b0;
        drive(1'b0, 11'h000, 6'd0, 1'b0, 1'b0);
        repeat (2) step();

        // Reset state
        check("rst instr_out",   32'(instr_out),   32'h0);
        check("rst counter_out", 32'(counter_out), 32'h0);
        check("rst valid_out",   32'(valid_out),   32'h0);
        check("rst occupancy",   32'(occupancy),   32'h0);
        check("rst retire_cnt",  32'(retire_cnt),  32'h0);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].vi, vecs[i].instr, vecs[i].pc, vecs[i].st, vecs[i].fl);
            step();
            check($sformatf("v%0d instr_out", i),   32'(instr_out),   32'(vecs[i].ei));
            check($sformatf("v%0d counter_out", i), 32'(counter_out), 32'(vecs[i].ep));
            check($sformatf("v%0d valid_out", i),   32'(valid_out),   32'(vecs[i].ev));
            check($sformatf("v%0d occupancy", i),   32'(occupancy),   32'(vecs[i].eo));
            check($sformatf("v%0d retire_cnt", i),  32'(retire_cnt),  32'(vecs[i].er));
            check($sformatf("v%0d wrap retire", i), 32'(retire_w),    32'(vecs[i].er[3:0]));
`ifdef PIPE_STAGE_TAP_EN
            check($sformatf("v%0d tap last valid", i), 32'(tap_valid3[2]),     32'(vecs[i].ev));
            check($sformatf("v%0d tap last instr", i), 32'(tap_instr3[32:22]), 32'(vecs[i].ei));
`endif
        end

        // Async reset mid-stream with a full pipe, no clock edge involved
        drive(1'b1, 11'h011, 6'd1, 1'b0, 1'b0); step();
        drive(1'b1, 11'h022, 6'd2, 1'b0, 1'b0); step();
        drive(1'b1, 11'h033, 6'd3, 1'b0, 1'b0); step();
        check("prerst occupancy", 32'(occupancy), 32'd3);
        #3;
        rst_n = 1'b0;
        #1;
        check("async instr_out",   32'(instr_out),   32'h0);
        check("async counter_out", 32'(counter_out), 32'h0);
        check("async valid_out",   32'(valid_out),   32'h0);
        check("async occupancy",   32'(occupancy),   32'h0);
        check("async retire_cnt",  32'(retire_cnt),  32'h0);
        check("async wrap retire", 32'(retire_w),    32'h0);
        #1;
        rst_n = 1'b1;

        // Retire 17 instructions: 4-bit counter wraps to 1
        for (int i = 0; i < 20; i++) begin
            drive(i < 17, 11'(i + 1), 6'(i), 1'b0, 1'b0);
            step();
        end
        check("wrap retire16",  32'(retire_cnt), 32'd17);
        check("wrap retire4",   32'(retire_w),   32'd1);
        check("wrap occupancy", 32'(occupancy),  32'd0);
        check("wrap valid_out", 32'(valid_out),  32'd0);

        // Single-stage instance: plain register, one edge of latency
        drive(1'b1, 11'h5A5, 6'd9, 1'b0, 1'b0);
        step();
        check_one("s1a", 11'h5A5, 6'd9, 1'b1);
        check("s1a main still empty", 32'(valid_out), 32'd0);
        drive(1'b0, 11'h7FF, 6'd3, 1'b0, 1'b0);
        step();
        check_one("s1b", 11'h000, 6'd0, 1'b0);
        drive(1'b1, 11'h2C4, 6'd5, 1'b1, 1'b0);
        step();
        check_one("s1c", 11'h000, 6'd0, 1'b0);
        drive(1'b1, 11'h2C4, 6'd5, 1'b0, 1'b0);
        step();
        check_one("s1d", 11'h2C4, 6'd5, 1'b1);
        check("s1d main instr_out", 32'(instr_out), 32'h5A5);
        drive(1'b0, 11'h000, 6'd0, 1'b0, 1'b0);
        step();
        check_one("s1e", 11'h000, 6'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
